// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Brief    : External memory port bundle (req/ready handshake) shared by
//             the fetch and MEM-stage requesters via mem_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side issues requests; memory side answers with ready/rdata.
    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one memory port between instruction fetch and MEM-stage
//             data access, with stall outputs and a sticky wait timeout.
//             Optional macro MEM_ARB_ALTERNATE_EN: alternate grants on
//             contention so fetch waits at most one data access.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire                clk,
    input  wire                reset,

    input  wire                if_req,
    input  wire  [ADDR_W-1:0]  if_addr,
    output logic [DATA_W-1:0]  if_rdata,
    output logic               if_done,

    input  wire                dm_req,
    input  wire                dm_we,
    input  wire  [ADDR_W-1:0]  dm_addr,
    input  wire  [DATA_W-1:0]  dm_wdata,
    output logic [DATA_W-1:0]  dm_rdata,
    output logic               dm_done,

    output logic               pc_stall,
    output logic               pipe_stall,

    mem_port_arbiter_if.master mem,

    output logic               timeout_err
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_IF_WAIT = 2'd1;
    localparam logic [1:0] c_DM_WAIT = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;

    // Counter value seen in the last WAIT cycle before the abort edge.
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]        r_state;
    logic [7:0]        r_wait_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_done;
    logic              r_dm_done;
    logic              r_timeout_err;

    logic              w_grant_dm;
    logic              w_in_wait;

`ifdef MEM_ARB_ALTERNATE_EN
    // 1 = last grant went to data, 0 = to fetch.
    logic              r_last_grant;

    assign w_grant_dm = dm_req & ~(if_req & r_last_grant);
`else
    // Older instruction in MEM must finish before a younger fetch proceeds.
    assign w_grant_dm = dm_req;
`endif

    assign w_in_wait = (r_state == c_IF_WAIT) || (r_state == c_DM_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_wait_cnt    <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_if_rdata    <= '0;
            r_dm_rdata    <= '0;
            r_if_done     <= 1'b0;
            r_dm_done     <= 1'b0;
            r_timeout_err <= 1'b0;
`ifdef MEM_ARB_ALTERNATE_EN
            r_last_grant  <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_wait_cnt <= '0;
                    if (w_grant_dm) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                        r_state     <= c_DM_WAIT;
`ifdef MEM_ARB_ALTERNATE_EN
                        r_last_grant <= 1'b1;
`endif
                    end else if (if_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_state     <= c_IF_WAIT;
`ifdef MEM_ARB_ALTERNATE_EN
                        r_last_grant <= 1'b0;
`endif
                    end
                end

                c_IF_WAIT, c_DM_WAIT: begin
                    if (mem.mem_ready) begin
                        // Stores capture rdata as well; the value is ignored.
                        if (r_state == c_DM_WAIT) begin
                            r_dm_rdata <= mem.mem_rdata;
                            r_dm_done  <= 1'b1;
                        end else begin
                            r_if_rdata <= mem.mem_rdata;
                            r_if_done  <= 1'b1;
                        end
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= c_RESP;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        if (r_state == c_DM_WAIT) begin
                            r_dm_rdata <= '0;
                            r_dm_done  <= 1'b1;
                        end else begin
                            r_if_rdata <= '0;
                            r_if_done  <= 1'b1;
                        end
                        r_timeout_err <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_mem_we      <= 1'b0;
                        r_state       <= c_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end

                c_RESP: begin
                    // Requester drops or replaces its request this cycle.
                    r_if_done <= 1'b0;
                    r_dm_done <= 1'b0;
                    r_state   <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req   = r_mem_req & w_in_wait;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;

    assign if_rdata    = r_if_rdata;
    assign dm_rdata    = r_dm_rdata;
    assign if_done     = r_if_done;
    assign dm_done     = r_dm_done;
    assign timeout_err = r_timeout_err;

    assign pc_stall   = if_req & ~r_if_done;
    assign pipe_stall = dm_req & ~r_dm_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Directed self-checking bench for mem_port_arbiter; a second
//             instance with TIMEOUT_CYCLES = 4 exercises the abort path.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic        is_dm;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata_drv;
    logic        auto_mem;
    logic [31:0] rd_bus;

    logic [31:0] if_rdata, dm_rdata, if_rdata_t, dm_rdata_t;
    logic        if_done, dm_done, pc_stall, pipe_stall, timeout_err;
    logic        if_done_t, dm_done_t, pc_stall_t, pipe_stall_t, timeout_err_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif_to();

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    assign rd_bus           = auto_mem ? mem_model(mif.mem_addr) : mem_rdata_drv;
    assign mif.mem_ready    = mem_ready;
    assign mif.mem_rdata    = rd_bus;
    assign mif_to.mem_ready = mem_ready;
    assign mif_to.mem_rdata = rd_bus;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .pc_stall(pc_stall), .pipe_stall(pipe_stall),
        .mem(mif), .timeout_err(timeout_err)
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_t), .if_done(if_done_t),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata_t), .dm_done(dm_done_t),
        .pc_stall(pc_stall_t), .pipe_stall(pipe_stall_t),
        .mem(mif_to), .timeout_err(timeout_err_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        chk({tag, "_sb_pending"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_if_done"}, {31'd0, if_done}, {31'd0, ~e.is_dm});
            chk({tag, "_dm_done"}, {31'd0, dm_done}, {31'd0, e.is_dm});
            if (e.chk_data)
                chk({tag, "_rdata"}, e.is_dm ? dm_rdata : if_rdata, e.data);
        end
    endtask

    // One access from an idle arbiter; mem_ready arrives in WAIT cycle k+1.
    task automatic run_access(input logic is_dm, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int k, input logic toggle, input string tag);
        exp_t e;
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        e.is_dm = is_dm; e.chk_data = ~we; e.data = rdata;
        sb.push_back(e);
        step();
        for (int i = 0; i <= k; i++) begin
            chk({tag, "_mem_req"}, {31'd0, mif.mem_req}, 32'd1);
            chk({tag, "_mem_we"}, {31'd0, mif.mem_we}, {31'd0, we});
            chk({tag, "_mem_addr"}, mif.mem_addr, addr);
            if (we) chk({tag, "_mem_wdata"}, mif.mem_wdata, wdata);
            chk({tag, "_stall_wait"}, {31'd0, is_dm ? pipe_stall : pc_stall}, 32'd1);
            chk({tag, "_no_early_done"}, {31'd0, if_done | dm_done}, 32'd0);
            if (toggle) begin
                dm_addr = ~dm_addr; dm_wdata = ~dm_wdata;
            end
            if (i == k) begin
                mem_ready = 1'b1; mem_rdata_drv = rdata;
            end
            step();
        end
        mem_ready = 1'b0; mem_rdata_drv = '0;
        check_done(tag);
        chk({tag, "_stall_done"}, {31'd0, is_dm ? pipe_stall : pc_stall}, 32'd0);
        chk({tag, "_req_drop"}, {31'd0, mif.mem_req}, 32'd0);
        if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
        step();
        chk({tag, "_done_1cyc"}, {31'd0, if_done | dm_done}, 32'd0);
    endtask

    initial begin
        exp_t e;
        logic was_dm, was_if;
        int   n_dm;

        reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_ready = 1'b0; mem_rdata_drv = '0; auto_mem = 1'b0;
        repeat (3) step();

        chk("rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mif.mem_we}, 32'd0);
        chk("rst_mem_addr", mif.mem_addr, 32'd0);
        chk("rst_mem_wdata", mif.mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_dones", {30'd0, if_done, dm_done}, 32'd0);
        chk("rst_stalls", {30'd0, pc_stall, pipe_stall}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        reset = 1'b0;
        step();

        run_access(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h2008_0005, 1, 1'b0, "fetch");
        run_access(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, "store");

        // Contention: data re-requests immediately after its first completion.
        auto_mem = 1'b1; mem_ready = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0200;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300;
        e.chk_data = 1'b1;
        e.is_dm = 1'b1; e.data = mem_model(32'h300); sb.push_back(e);
`ifdef MEM_ARB_ALTERNATE_EN
        e.is_dm = 1'b0; e.data = mem_model(32'h200); sb.push_back(e);
        e.is_dm = 1'b1; e.data = mem_model(32'h304); sb.push_back(e);
`else
        e.is_dm = 1'b1; e.data = mem_model(32'h304); sb.push_back(e);
        e.is_dm = 1'b0; e.data = mem_model(32'h200); sb.push_back(e);
`endif
        n_dm = 0;
        for (int cyc = 0; cyc < 40 && sb.size() != 0; cyc++) begin
            step();
            if (if_done | dm_done) begin
                was_dm = dm_done; was_if = if_done;
                check_done("contend");
                if (was_dm) begin
                    n_dm++;
                    if (n_dm == 1) dm_addr = 32'h0000_0304;
                    else dm_req = 1'b0;
                end
                if (was_if) if_req = 1'b0;
            end
        end
        chk("contend_all_served", 32'(sb.size()), 32'd0);
        mem_ready = 1'b0; auto_mem = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        step(); step();

        run_access(1'b1, 1'b1, 32'h0000_0A00, 32'h1234_5678, 32'h0, 9, 1'b1, "stable");

        // Reset in the 2nd DM_WAIT cycle.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0500;
        step();
        chk("rstmid_wait1", {31'd0, mif.mem_req}, 32'd1);
        step();
        chk("rstmid_wait2", {31'd0, mif.mem_req}, 32'd1);
        reset = 1'b1;
        step();
        chk("rstmid_req_drop", {31'd0, mif.mem_req}, 32'd0);
        chk("rstmid_no_done", {31'd0, dm_done}, 32'd0);
        chk("rstmid_if_rdata_clr", if_rdata, 32'd0);
        reset = 1'b0; dm_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstmid_quiet_done", {31'd0, dm_done}, 32'd0);
            chk("rstmid_quiet_req", {31'd0, mif.mem_req}, 32'd0);
        end
        run_access(1'b0, 1'b0, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 0, 1'b0, "fresh");

        // Timeout on the TIMEOUT_CYCLES = 4 instance.
        if_req = 1'b1; if_addr = 32'h0000_0700;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("to_req_wait", {31'd0, mif_to.mem_req}, 32'd1);
            chk("to_no_early_done", {31'd0, if_done_t}, 32'd0);
            chk("to_err_early", {31'd0, timeout_err_t}, 32'd0);
            step();
        end
        chk("to_done", {31'd0, if_done_t}, 32'd1);
        chk("to_rdata_zero", if_rdata_t, 32'd0);
        chk("to_err_set", {31'd0, timeout_err_t}, 32'd1);
        chk("to_req_drop", {31'd0, mif_to.mem_req}, 32'd0);
        chk("to_main_still_wait", {31'd0, mif.mem_req}, 32'd1);
        if_req = 1'b0;
        step();
        chk("to_done_1cyc", {31'd0, if_done_t}, 32'd0);
        chk("to_err_sticky", {31'd0, timeout_err_t}, 32'd1);
        mem_ready = 1'b1; mem_rdata_drv = 32'h1;
        step();
        mem_ready = 1'b0; mem_rdata_drv = '0;
        step(); step();

        run_access(1'b1, 1'b0, 32'h0000_0800, 32'h0, 32'hCAFE_0001, 2, 1'b0, "after_to");
        chk("to_err_after_ok", {31'd0, timeout_err_t}, 32'd1);
        chk("to_inst_rdata_ok", dm_rdata_t, 32'hCAFE_0001);
        chk("main_no_timeout", {31'd0, timeout_err}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("to_err_reset_clr", {31'd0, timeout_err_t}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
